// File: rtl/conv_sequencer.sv
// ---------------------------------------------------------------------------
// conv_sequencer
//
// Controller for a P-lane FIR convolution datapath made of an X sample RAM,
// an F coefficient ROM, P multiply-accumulate lanes and a Y output RAM.
// It generates addresses and strobes only. It never holds sample data.
//
// Frame sequence:
//   LOAD    - accept N samples over a valid/ready handshake and write them to X RAM.
//   COMPUTE - run ceil(SIZE/P) lane groups of M taps each, then commit each
//             group's lane results to Y RAM.
//   DRAIN   - stream the SIZE = N-M+1 results out over a valid/ready handshake.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   s_valid_x / s_ready_x   input sample handshake
//   x_we, x_waddr           X RAM write port
//   x_raddr                 X RAM read addresses, lane l at [l*ADDRX +: ADDRX]
//   f_addr                  F ROM address, shared by all lanes
//   clr_acc, en_acc         per-lane accumulator clear / enable
//   y_we, y_lane_en         Y RAM write strobe and per-lane write mask
//   y_waddr                 Y RAM base write address (lane l writes y_waddr+l)
//   y_raddr                 Y RAM read address (the RAM registers its read data)
//   m_valid_y / m_ready_y   output sample handshake
//   frame_cnt               completed-frame counter (only with the optional build)
//
// Optional build: define CONV_SEQ_FRAME_CNT_EN to add the 16-bit frame_cnt
// output. It counts completed frames and wraps from 0xFFFF back to 0.
// ---------------------------------------------------------------------------
module conv_sequencer #(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int P     = 2,
    parameter int ADDRX = 3,
    parameter int ADDRF = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid_x,
    output logic               s_ready_x,
    output logic               x_we,
    output logic [ADDRX-1:0]   x_waddr,
    output logic [P*ADDRX-1:0] x_raddr,
    output logic [ADDRF-1:0]   f_addr,
    output logic [P-1:0]       clr_acc,
    output logic [P-1:0]       en_acc,
    output logic               y_we,
    output logic [P-1:0]       y_lane_en,
    output logic [ADDRX-1:0]   y_waddr,
    output logic [ADDRX-1:0]   y_raddr,
    output logic               m_valid_y,
`ifdef CONV_SEQ_FRAME_CNT_EN
    output logic [15:0]        frame_cnt,
`endif
    input  logic               m_ready_y
);

    localparam int SIZE = N - M + 1;
    localparam int G    = (SIZE + P - 1) / P;
    // One extra bit so that address sums cannot wrap before the clamp and compare.
    localparam int AW   = ADDRX + 1;
    localparam int TW   = $clog2(M + 2);
    localparam int GW   = $clog2(G + 1);

    localparam logic [AW-1:0] LAST_X = AW'(N - 1);
    localparam logic [AW-1:0] SIZE_A = AW'(SIZE);
    localparam logic [AW-1:0] LAST_Y = AW'(SIZE - 1);
    localparam logic [AW-1:0] P_A    = AW'(P);
    localparam logic [TW-1:0] T_M    = TW'(M);
    localparam logic [TW-1:0] T_DONE = TW'(M + 1);
    localparam logic [GW-1:0] LAST_G = GW'(G - 1);

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN
    } state_t;

    state_t        state, next_state;
    logic [AW-1:0] wcnt;
    logic [AW-1:0] base;
    logic [AW-1:0] rd_idx;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] grp;
    logic          mvalid_q;

    logic          accept;
    logic          handshake;
    logic          last_beat;
    logic          last_tap;
    logic          last_group;
    logic          last_rd;
    logic [AW-1:0] addr_sum;

`ifdef CONV_SEQ_FRAME_CNT_EN
    logic [15:0]   frame_cnt_q;
    // Gate the counter so that every output reads 0 while reset is held.
    assign frame_cnt = reset ? 16'd0 : frame_cnt_q;
`endif

    // State register and counters. wcnt counts accepted samples, tcnt is the
    // cycle within a group, grp and base select the group, and rd_idx is the
    // drain pointer. m_valid_y is registered. It rises on the cycle after
    // DRAIN is entered and falls only after the final handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            wcnt     <= '0;
            base     <= '0;
            rd_idx   <= '0;
            tcnt     <= '0;
            grp      <= '0;
            mvalid_q <= 1'b0;
`ifdef CONV_SEQ_FRAME_CNT_EN
            frame_cnt_q <= 16'd0;
`endif
        end else begin
            state <= next_state;
            case (state)
                LOAD: begin
                    if (accept) begin
                        wcnt <= last_beat ? '0 : wcnt + AW'(1);
                        if (last_beat) begin
                            tcnt <= '0;
                            grp  <= '0;
                            base <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    if (last_tap) begin
                        tcnt <= '0;
                        grp  <= grp + GW'(1);
                        base <= base + P_A;
                        if (last_group) begin
                            rd_idx <= '0;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        rd_idx <= last_rd ? '0 : rd_idx + AW'(1);
                    end
                end
                default: ;
            endcase
            mvalid_q <= (state == DRAIN) && !(handshake && last_rd);
`ifdef CONV_SEQ_FRAME_CNT_EN
            if (handshake && last_rd) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
`endif
        end
    end

    // Next state and all strobes and addresses. In COMPUTE, a lane whose
    // output index b+l falls past SIZE-1 is masked for the whole group.
    // Read addresses that would run past the end of X RAM are clamped to N-1
    // so the RAM is never addressed out of range. y_raddr moves ahead in the
    // same cycle as a handshake, so the registered RAM output already holds
    // the next sample when m_valid_y is sampled again.
    always_comb begin
        next_state = state;
        s_ready_x  = 1'b0;
        x_we       = 1'b0;
        x_waddr    = '0;
        x_raddr    = '0;
        f_addr     = '0;
        clr_acc    = '0;
        en_acc     = '0;
        y_we       = 1'b0;
        y_lane_en  = '0;
        y_waddr    = '0;
        y_raddr    = '0;
        m_valid_y  = 1'b0;
        addr_sum   = '0;

        accept     = (state == LOAD) && s_valid_x;
        handshake  = (state == DRAIN) && mvalid_q && m_ready_y;
        last_beat  = (wcnt == LAST_X);
        last_tap   = (tcnt == T_DONE);
        last_group = (grp == LAST_G);
        last_rd    = (rd_idx == LAST_Y);

        case (state)
            LOAD: begin
                s_ready_x = 1'b1;
                x_we      = accept;
                x_waddr   = ADDRX'(wcnt);
                if (accept && last_beat) begin
                    next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                if (tcnt < T_M) begin
                    f_addr = ADDRF'(tcnt);
                    for (int l = 0; l < P; l++) begin
                        addr_sum = base + AW'(l) + AW'(tcnt);
                        if (addr_sum > LAST_X) begin
                            addr_sum = LAST_X;
                        end
                        x_raddr[l*ADDRX +: ADDRX] = ADDRX'(addr_sum);
                    end
                end
                if (tcnt == '0) begin
                    clr_acc = '1;
                end else if (tcnt <= T_M) begin
                    for (int l = 0; l < P; l++) begin
                        en_acc[l] = (base + AW'(l)) < SIZE_A;
                    end
                end else begin
                    y_we    = 1'b1;
                    y_waddr = ADDRX'(base);
                    for (int l = 0; l < P; l++) begin
                        y_lane_en[l] = (base + AW'(l)) < SIZE_A;
                    end
                    if (last_group) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                m_valid_y = mvalid_q;
                y_raddr   = ADDRX'(handshake ? rd_idx + AW'(1) : rd_idx);
                if (handshake && last_rd) begin
                    next_state = LOAD;
                end
            end
            default: begin
                next_state = LOAD;
            end
        endcase

        if (reset) begin
            s_ready_x = 1'b0;
            x_we      = 1'b0;
            x_waddr   = '0;
            x_raddr   = '0;
            f_addr    = '0;
            clr_acc   = '0;
            en_acc    = '0;
            y_we      = 1'b0;
            y_lane_en = '0;
            y_waddr   = '0;
            y_raddr   = '0;
            m_valid_y = 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_sequencer
//
// Testbench for conv_sequencer (N=8, M=4, P=2). It contains behavioural
// models of the X RAM, F ROM, MAC lanes and Y RAM. Expected output samples
// go into a scoreboard queue when a frame's stimulus is built. They are
// popped and compared on every output handshake. The bench also follows the
// control strobes (load addresses, group timing, lane masks and drain
// latency) and checks reset behaviour.
// When CONV_SEQ_FRAME_CNT_EN is defined, it also checks frame_cnt.
// ---------------------------------------------------------------------------
module tb_conv_sequencer;

    localparam int N     = 8;
    localparam int M     = 4;
    localparam int P     = 2;
    localparam int ADDRX = 3;
    localparam int ADDRF = 2;
    localparam int SIZE  = N - M + 1;
    localparam int G     = (SIZE + P - 1) / P;

    logic               clk;
    logic               reset;
    logic               s_valid_x;
    logic               s_ready_x;
    logic               x_we;
    logic [ADDRX-1:0]   x_waddr;
    logic [P*ADDRX-1:0] x_raddr;
    logic [ADDRF-1:0]   f_addr;
    logic [P-1:0]       clr_acc;
    logic [P-1:0]       en_acc;
    logic               y_we;
    logic [P-1:0]       y_lane_en;
    logic [ADDRX-1:0]   y_waddr;
    logic [ADDRX-1:0]   y_raddr;
    logic               m_valid_y;
    logic               m_ready_y;
`ifdef CONV_SEQ_FRAME_CNT_EN
    logic [15:0]        frame_cnt;
`endif

    logic [31:0] x_data;
    logic [31:0] xram [N];
    logic [31:0] yram [N];
    logic [31:0] xrd  [P];
    logic [31:0] acc  [P];
    logic [31:0] frd;
    logic [31:0] yrd;
    int          fmem [M];
    int          n_checks;
    int          n_fail;
    int unsigned sb [$];

    logic [26:0] all_outs;
    assign all_outs = {s_ready_x, x_we, x_waddr, x_raddr, f_addr, clr_acc, en_acc,
                       y_we, y_lane_en, y_waddr, y_raddr, m_valid_y};

    conv_sequencer #(.N(N), .M(M), .P(P), .ADDRX(ADDRX), .ADDRF(ADDRF)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid_x (s_valid_x),
        .s_ready_x (s_ready_x),
        .x_we      (x_we),
        .x_waddr   (x_waddr),
        .x_raddr   (x_raddr),
        .f_addr    (f_addr),
        .clr_acc   (clr_acc),
        .en_acc    (en_acc),
        .y_we      (y_we),
        .y_lane_en (y_lane_en),
        .y_waddr   (y_waddr),
        .y_raddr   (y_raddr),
        .m_valid_y (m_valid_y),
`ifdef CONV_SEQ_FRAME_CNT_EN
        .frame_cnt (frame_cnt),
`endif
        .m_ready_y (m_ready_y)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath. X RAM, F ROM and Y RAM all have registered reads.
    // Each MAC lane clears or accumulates from the read data of the previous
    // cycle. Y RAM stores each lane's accumulator at base+lane when that
    // lane's mask bit is set.
    always @(posedge clk) begin
        if (x_we) xram[x_waddr] <= x_data;
        frd <= 32'(fmem[f_addr]);
        for (int l = 0; l < P; l++) begin
            xrd[l] <= xram[x_raddr[l*ADDRX +: ADDRX]];
            if (clr_acc[l]) acc[l] <= '0;
            else if (en_acc[l]) acc[l] <= acc[l] + xrd[l] * frd;
            if (y_we && y_lane_en[l]) yram[int'(y_waddr) + l] <= acc[l];
        end
        yrd <= yram[y_raddr];
    end

    // Counts every comparison and reports each mismatch on its own line.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Holds reset for the given number of cycles and checks that all outputs
    // are zero throughout. It then releases reset, checks the idle LOAD
    // outputs and flushes any results left from an aborted frame.
    task automatic doReset(input int cycles);
        reset     = 1'b1;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        x_data    = '0;
        repeat (cycles) begin
            @(negedge clk);
            checkOutput("reset_outs", 32'(all_outs), 0);
`ifdef CONV_SEQ_FRAME_CNT_EN
            checkOutput("reset_frame_cnt", 32'(frame_cnt), 0);
`endif
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(s_ready_x), 1);
        checkOutput("valid_after_reset", 32'(m_valid_y), 0);
        @(posedge clk);
        #1;
    endtask

    // Runs one frame. It builds the samples (a 1..N ramp or random values),
    // queues the expected convolution results when use_model is set, and
    // then steps cycle by cycle within a bounded budget. Each step checks the
    // load handshake, group strobes, drain latency, valid hold and the
    // scoreboard. s_valid_x stays high after loading, which also checks that
    // no sample is accepted outside LOAD. abort_mid stops the frame at group 1,
    // tap 2, so the caller can pulse reset there.
    task automatic applyStimulus(input bit toggle_ready, input bit use_ramp,
                                 input bit use_model, input bit abort_mid);
        int xs [N];
        int en_cnt [P];
        int beat = 0, cyc = 0, hs = 0, grp = 0, sum = 0;
        int entry = -1, first_acc = -1, last_acc = -1, abort_at = -1;
        bit seen_valid = 0, prev_valid = 0, prev_ready = 0, done = 0, aborted = 0;
        bit lane_ok;
        int unsigned exp_v;

        for (int i = 0; i < N; i++) xs[i] = use_ramp ? i + 1 : int'($urandom_range(0, 255));
        if (use_model) begin
            for (int i = 0; i < SIZE; i++) begin
                sum = 0;
                for (int k = 0; k < M; k++) sum += xs[i+k] * fmem[k];
                sb.push_back(sum);
            end
        end
        for (int l = 0; l < P; l++) en_cnt[l] = 0;

        while (!done && cyc < 300) begin
            if (abort_mid && cyc == abort_at) begin
                aborted = 1;
                break;
            end
            s_valid_x = 1'b1;
            x_data    = (beat < N) ? 32'(xs[beat]) : 32'd0;
            m_ready_y = toggle_ready ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);

            if (beat < N) begin
                if (s_ready_x) begin
                    checkOutput("x_we", 32'(x_we), 1);
                    checkOutput("x_waddr", 32'(x_waddr), beat);
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    beat++;
                end
            end else begin
                checkOutput("no_accept", 32'({s_ready_x, x_we}), 0);
            end

            for (int l = 0; l < P; l++) en_cnt[l] += int'(en_acc[l]);

            if (clr_acc != '0) begin
                checkOutput("clr_all", 32'(clr_acc), 32'({P{1'b1}}));
                if (entry < 0) begin
                    entry = cyc;
                    checkOutput("compute_entry", cyc, last_acc + 1);
                    checkOutput("load_span", last_acc - first_acc, N - 1);
                end
                if (abort_mid && grp == 1) abort_at = cyc + 2;
            end

            if (y_we) begin
                checkOutput("y_waddr", 32'(y_waddr), grp * P);
                for (int l = 0; l < P; l++) begin
                    lane_ok = (grp * P + l) < SIZE;
                    checkOutput("y_lane_en", 32'(y_lane_en[l]), 32'(lane_ok));
                    checkOutput("en_acc_cycles", en_cnt[l], lane_ok ? M : 0);
                    en_cnt[l] = 0;
                end
                grp++;
            end

            if (m_valid_y && !seen_valid) begin
                seen_valid = 1;
                checkOutput("drain_latency", cyc - entry, G * (M + 2) + 1);
            end
            if (prev_valid && !prev_ready) checkOutput("valid_hold", 32'(m_valid_y), 1);
            prev_valid = m_valid_y;
            prev_ready = m_ready_y;

            if (m_valid_y && m_ready_y) begin
                checkOutput("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_v = sb.pop_front();
                    checkOutput("y_data", yrd, exp_v);
                end
                hs++;
                if (hs == SIZE) begin
                    done      = 1;
                    s_valid_x = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        s_valid_x = 1'b0;

        if (!aborted) begin
            checkOutput("handshakes", hs, SIZE);
            checkOutput("groups", grp, G);
            @(negedge clk);
            checkOutput("valid_fall", 32'(m_valid_y), 0);
            checkOutput("reload_ready", 32'(s_ready_x), 1);
            @(posedge clk);
            #1;
        end
    endtask

    // Test sequence: reset, a ramp frame with unit taps, a random frame with
    // a toggling ready, a frame aborted by reset in mid-compute, then three
    // back-to-back random frames.
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        x_data    = '0;
        for (int k = 0; k < M; k++) fmem[k] = 1;

        $display("[TB] reset");
        doReset(3);

        $display("[TB] ramp frame, unit taps");
        sb.push_back(10);
        sb.push_back(14);
        sb.push_back(18);
        sb.push_back(22);
        sb.push_back(26);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] random frame, ready toggling");
        fmem[0] = 2; fmem[1] = 0; fmem[2] = 3; fmem[3] = 1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset in mid-compute");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        doReset(2);

        $display("[TB] three back-to-back frames");
        fmem[0] = 5; fmem[1] = 7; fmem[2] = 1; fmem[3] = 9;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
`ifdef CONV_SEQ_FRAME_CNT_EN
        checkOutput("frame_cnt", 32'(frame_cnt), 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
